// File: rtl/inst_fetch_if.sv
// Fetch-unit signal bundle: control strobes, instruction-RAM read port and decoder handshake.
// master = the fetch block, slave = its environment (control unit, RAM, decoder).
interface inst_fetch_if;
    logic        en;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [1:0]  fifo_count;

    modport master (
        input  en, redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
        output mem_req, mem_addr, inst, inst_pc, inst_valid, fifo_count
    );

    modport slave (
        output en, redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
        input  mem_req, mem_addr, inst, inst_pc, inst_valid, fifo_count
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding RAM request FSM feeding a 2-entry {pc, word} prefetch FIFO.
// Optional macro FETCH_BYPASS_EN offers a returning word to the decoder in its ack cycle when the FIFO is empty.
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    inst_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t      state;
    logic [15:0] fetch_pc;
    logic        mem_req_q;
    logic [15:0] mem_addr_q;
    logic [1:0]  count;
    logic [15:0] pc_q   [2];
    logic [15:0] word_q [2];

    logic        ack_take;
    logic        head_vld;
    logic        pop;
    logic        push;
    logic        byp_hit;
    logic        byp_take;
    logic [1:0]  count_nxt;
    logic [15:0] fetch_pc_inc;

    // Event decode: a redirect masks every push and pop in its cycle.
    always_comb begin
        ack_take = (state == REQ) && bus.mem_ack && !bus.redirect;
        head_vld = (count != 2'd0);
        pop      = head_vld && bus.inst_ready && !bus.redirect;
`ifdef FETCH_BYPASS_EN
        byp_hit  = ack_take && !head_vld;
`else
        byp_hit  = 1'b0;
`endif
        byp_take     = byp_hit && bus.inst_ready;
        push         = ack_take && !byp_take;
        fetch_pc_inc = fetch_pc + 16'd1;
        if (bus.redirect) begin
            count_nxt = 2'd0;
        end else begin
            count_nxt = count + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage: slot 0 is the head; a push lands behind whatever survives the pop.
    always_ff @(posedge clk) begin
        if (pop) begin
            pc_q[0]   <= pc_q[1];
            word_q[0] <= word_q[1];
        end
        if (push) begin
            if (count_nxt == 2'd2) begin
                pc_q[1]   <= fetch_pc;
                word_q[1] <= bus.mem_rdata;
            end else begin
                pc_q[0]   <= fetch_pc;
                word_q[0] <= bus.mem_rdata;
            end
        end
    end

    // Request FSM and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            count      <= 2'd0;
        end else begin
            count <= count_nxt;
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
            end
            case (state)
                IDLE: begin
                    if (!bus.redirect && bus.en && count != 2'd2) begin
                        state      <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc;
                    end
                end
                REQ: begin
                    if (bus.redirect) begin
                        if (bus.mem_ack) begin
                            state     <= IDLE;
                            mem_req_q <= 1'b0;
                        end else begin
                            state <= DROP;
                        end
                    end else if (bus.mem_ack) begin
                        fetch_pc <= fetch_pc_inc;
                        if (bus.en && count_nxt != 2'd2) begin
                            mem_addr_q <= fetch_pc_inc;
                        end else begin
                            state     <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    // The in-flight word belongs to the abandoned path; just wait it out.
                    if (bus.mem_ack) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Decoder side: FIFO head, else the bypassed RAM word, else zeros.
    always_comb begin
        bus.mem_req    = mem_req_q;
        bus.mem_addr   = mem_addr_q;
        bus.fifo_count = count;
        bus.inst_valid = head_vld || byp_hit;
        if (head_vld) begin
            bus.inst    = word_q[0];
            bus.inst_pc = pc_q[0];
        end else if (byp_hit) begin
            bus.inst    = bus.mem_rdata;
            bus.inst_pc = fetch_pc;
        end else begin
            bus.inst    = 16'h0000;
            bus.inst_pc = 16'h0000;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_inst_fetch;
    logic clk = 1'b0;
    logic reset;
    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ctl = {reset, en, redirect, mem_ack, inst_ready}; fl = {mem_req, inst_valid}
    typedef struct {
        logic [4:0]  ctl;
        logic [15:0] rpc;
        logic [15:0] rdata;
        logic [1:0]  fl;
        logic [15:0] addr;
        logic [1:0]  cnt;
        logic [15:0] ipc;
        logic [15:0] iw;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] w;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_fpc;
    logic [15:0] m_addr;
    bit          m_busy;
    bit          m_disc;

    function automatic vec_t mk(input logic [4:0] ctl, input logic [15:0] rpc, input logic [15:0] rdata,
                                input logic [1:0] fl, input logic [15:0] addr, input logic [1:0] cnt,
                                input logic [15:0] ipc, input logic [15:0] iw);
        vec_t v;
        v.ctl = ctl; v.rpc = rpc; v.rdata = rdata; v.fl = fl;
        v.addr = addr; v.cnt = cnt; v.ipc = ipc; v.iw = iw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [1:0] fl, input logic [15:0] addr,
                           input logic [1:0] cnt, input logic [15:0] ipc, input logic [15:0] iw);
        chk({nm, ".mem_req"},    16'(bus.mem_req),    16'(fl[1]));
        chk({nm, ".mem_addr"},   bus.mem_addr,        addr);
        chk({nm, ".fifo_count"}, 16'(bus.fifo_count), 16'(cnt));
        chk({nm, ".inst_valid"}, 16'(bus.inst_valid), 16'(fl[0]));
        chk({nm, ".inst_pc"},    bus.inst_pc,         ipc);
        chk({nm, ".inst"},       bus.inst,            iw);
    endtask

    task automatic apply(input logic [4:0] ctl, input logic [15:0] rpc, input logic [15:0] rdata);
        reset           = ctl[4];
        bus.en          = ctl[3];
        bus.redirect    = ctl[2];
        bus.mem_ack     = ctl[1];
        bus.inst_ready  = ctl[0];
        bus.redirect_pc = rpc;
        bus.mem_rdata   = rdata;
    endtask

    // One cycle of the reference model: compare current outputs, then advance by the sampled inputs.
    task automatic model_cycle(input bit do_chk, input int c);
        bit          byp;
        int          n0;
        logic [1:0]  e_fl;
        logic [15:0] e_pc;
        logic [15:0] e_w;
`ifdef FETCH_BYPASS_EN
        byp = m_busy && !m_disc && bus.mem_ack && !bus.redirect && (mq.size() == 0);
`else
        byp = 1'b0;
`endif
        if (mq.size() > 0) begin
            e_pc = mq[0].pc; e_w = mq[0].w;
        end else if (byp) begin
            e_pc = m_fpc; e_w = bus.mem_rdata;
        end else begin
            e_pc = 16'h0000; e_w = 16'h0000;
        end
        e_fl = {m_busy, (mq.size() > 0) || byp};
        if (do_chk) begin
            chk_out($sformatf("rnd%0d", c), e_fl, m_addr, 2'(mq.size()), e_pc, e_w);
        end

        if (!reset) begin
            mq.delete();
            m_fpc = 16'h0000; m_addr = 16'h0000; m_busy = 0; m_disc = 0;
        end else if (bus.redirect) begin
            if (m_busy && bus.mem_ack) begin
                m_busy = 0; m_disc = 0;
            end else if (m_busy) begin
                m_disc = 1;
            end
            mq.delete();
            m_fpc = bus.redirect_pc;
        end else begin
            n0 = mq.size();
            if (n0 > 0 && bus.inst_ready) void'(mq.pop_front());
            if (m_busy && bus.mem_ack) begin
                m_busy = 0;
                if (m_disc) begin
                    m_disc = 0;
                end else begin
                    if (!(byp && bus.inst_ready)) mq.push_back('{m_fpc, bus.mem_rdata});
                    m_fpc = m_fpc + 16'd1;
                    if (bus.en && mq.size() < 2) begin
                        m_busy = 1; m_addr = m_fpc;
                    end
                end
            end else if (!m_busy && bus.en && n0 < 2) begin
                m_busy = 1; m_addr = m_fpc;
            end
        end
    endtask

    initial begin
        vec_t tbl[24];
        ent_t got[$];

        apply(5'b00000, 16'h0000, 16'h0000);

`ifndef FETCH_BYPASS_EN
        tbl[0]  = mk(5'b00000, 16'h0000, 16'h0000, 2'b00, 16'h0000, 2'd0, 16'h0000, 16'h0000);
        tbl[1]  = mk(5'b11000, 16'h0000, 16'h0000, 2'b00, 16'h0000, 2'd0, 16'h0000, 16'h0000);
        tbl[2]  = mk(5'b11000, 16'h0000, 16'h0000, 2'b10, 16'h0000, 2'd0, 16'h0000, 16'h0000);
        tbl[3]  = mk(5'b11010, 16'h0000, 16'hA000, 2'b10, 16'h0000, 2'd0, 16'h0000, 16'h0000);
        tbl[4]  = mk(5'b11000, 16'h0000, 16'h0000, 2'b11, 16'h0001, 2'd1, 16'h0000, 16'hA000);
        tbl[5]  = mk(5'b11010, 16'h0000, 16'hA001, 2'b11, 16'h0001, 2'd1, 16'h0000, 16'hA000);
        tbl[6]  = mk(5'b11000, 16'h0000, 16'h0000, 2'b01, 16'h0001, 2'd2, 16'h0000, 16'hA000);
        tbl[7]  = mk(5'b11000, 16'h0000, 16'h0000, 2'b01, 16'h0001, 2'd2, 16'h0000, 16'hA000);
        tbl[8]  = mk(5'b11001, 16'h0000, 16'h0000, 2'b01, 16'h0001, 2'd2, 16'h0000, 16'hA000);
        tbl[9]  = mk(5'b11000, 16'h0000, 16'h0000, 2'b01, 16'h0001, 2'd1, 16'h0001, 16'hA001);
        tbl[10] = mk(5'b11011, 16'h0000, 16'hA002, 2'b11, 16'h0002, 2'd1, 16'h0001, 16'hA001);
        tbl[11] = mk(5'b10000, 16'h0000, 16'h0000, 2'b11, 16'h0003, 2'd1, 16'h0002, 16'hA002);
        tbl[12] = mk(5'b10010, 16'h0000, 16'hA003, 2'b11, 16'h0003, 2'd1, 16'h0002, 16'hA002);
        tbl[13] = mk(5'b10001, 16'h0000, 16'h0000, 2'b01, 16'h0003, 2'd2, 16'h0002, 16'hA002);
        tbl[14] = mk(5'b10001, 16'h0000, 16'h0000, 2'b01, 16'h0003, 2'd1, 16'h0003, 16'hA003);
        tbl[15] = mk(5'b10000, 16'h0000, 16'h0000, 2'b00, 16'h0003, 2'd0, 16'h0000, 16'h0000);
        tbl[16] = mk(5'b10100, 16'h0005, 16'h0000, 2'b00, 16'h0003, 2'd0, 16'h0000, 16'h0000);
        tbl[17] = mk(5'b11000, 16'h0000, 16'h0000, 2'b00, 16'h0003, 2'd0, 16'h0000, 16'h0000);
        tbl[18] = mk(5'b11100, 16'h0040, 16'h0000, 2'b10, 16'h0005, 2'd0, 16'h0000, 16'h0000);
        tbl[19] = mk(5'b11000, 16'h0000, 16'h0000, 2'b10, 16'h0005, 2'd0, 16'h0000, 16'h0000);
        tbl[20] = mk(5'b11011, 16'h0000, 16'hDEAD, 2'b10, 16'h0005, 2'd0, 16'h0000, 16'h0000);
        tbl[21] = mk(5'b11000, 16'h0000, 16'h0000, 2'b00, 16'h0005, 2'd0, 16'h0000, 16'h0000);
        tbl[22] = mk(5'b11010, 16'h0000, 16'hB040, 2'b10, 16'h0040, 2'd0, 16'h0000, 16'h0000);
        tbl[23] = mk(5'b10000, 16'h0000, 16'h0000, 2'b11, 16'h0041, 2'd1, 16'h0040, 16'hB040);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            apply(tbl[i].ctl, tbl[i].rpc, tbl[i].rdata);
            #1;
            chk_out($sformatf("vec%0d", i), tbl[i].fl, tbl[i].addr, tbl[i].cnt, tbl[i].ipc, tbl[i].iw);
        end
`endif

        // Reset while a request is outstanding, then a stray ack after release.
        @(negedge clk); apply(5'b01000, 16'h0000, 16'h0000);
        @(negedge clk); apply(5'b11000, 16'h0000, 16'h0000);
        @(negedge clk); apply(5'b00000, 16'h0000, 16'h0000);
        #1 chk("rst_req.mem_req_before", 16'(bus.mem_req), 16'd1);
        @(negedge clk); apply(5'b10011, 16'h0000, 16'h5555);
        #1;
        chk("rst_req.mem_req", 16'(bus.mem_req), 16'd0);
        chk("rst_req.mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_req.inst_valid", 16'(bus.inst_valid), 16'd0);
        @(negedge clk); apply(5'b10000, 16'h0000, 16'h0000);
        #1;
        chk("stray_ack.fifo_count", 16'(bus.fifo_count), 16'd0);
        chk("stray_ack.inst_valid", 16'(bus.inst_valid), 16'd0);
        chk("stray_ack.mem_req", 16'(bus.mem_req), 16'd0);

        // Wrap: redirect to FFFF, then stream with same-cycle acks.
        @(negedge clk); apply(5'b10100, 16'hFFFF, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            apply({3'b110, bus.mem_req, 1'b1}, 16'h0000, ~bus.mem_addr);
            #1;
            if (bus.inst_valid) got.push_back('{bus.inst_pc, bus.inst});
        end
        chk("wrap.count", 16'(got.size() >= 4), 16'd1);
        for (int k = 0; k < got.size() && k < 4; k++) begin
            chk($sformatf("wrap.pc%0d", k), got[k].pc, 16'hFFFF + 16'(k));
            chk($sformatf("wrap.word%0d", k), got[k].w, ~(16'hFFFF + 16'(k)));
        end

`ifdef FETCH_BYPASS_EN
        @(negedge clk); apply(5'b00000, 16'h0000, 16'h0000);
        @(negedge clk); apply(5'b11000, 16'h0000, 16'h0000);
        @(negedge clk); apply(5'b10011, 16'h0000, 16'h1234);
        #1;
        chk("byp.inst_valid", 16'(bus.inst_valid), 16'd1);
        chk("byp.inst", bus.inst, 16'h1234);
        chk("byp.inst_pc", bus.inst_pc, 16'h0000);
        chk("byp.fifo_count", 16'(bus.fifo_count), 16'd0);
        @(negedge clk); apply(5'b10000, 16'h0000, 16'h0000);
        #1;
        chk("byp.fifo_after", 16'(bus.fifo_count), 16'd0);
        chk("byp.valid_after", 16'(bus.inst_valid), 16'd0);
`endif

        // Randomized run against the reference model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset           = !((c == 0) || ($urandom_range(0, 199) == 0));
            bus.en          = ($urandom_range(0, 9) < 7);
            bus.redirect    = ($urandom_range(0, 99) < 8);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            bus.mem_ack     = ($urandom_range(0, 1) == 1);
            bus.mem_rdata   = 16'($urandom);
            bus.inst_ready  = ($urandom_range(0, 9) < 6);
            #1;
            model_cycle(c != 0, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: the fetch address loaded at reset.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-low reset.
REQ-004 Port en, input, 1: fetch enable from the control unit's fetch strobe.
REQ-005 Port redirect, input, 1: taken-branch flush.
REQ-006 Port redirect_pc, input, 16: the new fetch address, sampled when redirect=1.
REQ-007 Port mem_req, output, 1: registered instruction-RAM read request.
REQ-008 Port mem_addr, output, 16: the word address of the outstanding request.
REQ-009 Port mem_ack, input, 1: RAM read data valid.
REQ-010 Port mem_rdata, input, 16: RAM read data, valid when mem_ack=1.
REQ-011 Port inst, output, 16: the instruction word offered to the decoder.
REQ-012 Port inst_pc, output, 16: the address of inst.
REQ-013 Port inst_valid, output, 1: inst and inst_pc are valid.
REQ-014 Port inst_ready, input, 1: the decoder accepts inst this cycle.
REQ-015 Port fifo_count, output, 2: prefetch buffer occupancy, 0 to 2.

Function
REQ-016 The block SHALL contain a 2-entry FIFO of {pc, word} pairs and a 16-bit fetch_pc register.
REQ-017 The request FSM SHALL have exactly three states: IDLE (no request outstanding), REQ (one request outstanding), DROP (an outstanding request whose data is discarded).
REQ-018 IDLE->REQ SHALL occur when en=1, redirect=0 and fifo_count<2; on that edge mem_req goes to 1 and mem_addr takes fetch_pc.
REQ-019 At most one request SHALL be outstanding; mem_req and mem_addr SHALL stay stable in REQ until mem_ack=1.
REQ-020 A request SHALL complete when en drops to 0 mid-REQ; en gates only the issue of new requests.
REQ-021 In REQ with mem_ack=1, the block SHALL push {fetch_pc, mem_rdata} and increment fetch_pc by 1, wrapping 16'hFFFF to 16'h0000.
REQ-022 After that ack the FSM SHALL stay in REQ with the next address when en=1 and post-push/pop occupancy <2; otherwise it SHALL go to IDLE with mem_req=0.
REQ-023 A push SHALL never overflow, because issue requires occupancy ≤1 and a pop only lowers occupancy.
REQ-024 inst, inst_pc and inst_valid SHALL reflect the FIFO head; inst_valid = (fifo_count != 0).
REQ-025 A pop SHALL occur when inst_valid=1 and inst_ready=1; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-026 The default latency SHALL be one cycle from mem_ack to inst_valid for an empty FIFO.
REQ-027 redirect=1 SHALL override every other event in its cycle:
- the FIFO is flushed (fifo_count=0);
- fetch_pc loads redirect_pc;
- any pop is ignored.
REQ-028 redirect=1 in REQ with mem_ack=0 SHALL move the FSM to DROP with mem_req held until the ack.
REQ-029 redirect=1 in REQ with mem_ack=1 SHALL discard the returned data and move the FSM to IDLE.
REQ-030 In DROP, mem_ack SHALL discard the data, leave fetch_pc and the FIFO unchanged, and move the FSM to IDLE.
REQ-031 A second redirect arriving in DROP SHALL only reload fetch_pc.
REQ-032 Leaving DROP or a redirect SHALL never cause an issue in the same cycle; the next request comes from IDLE per REQ-018.

Reset
REQ-033 When reset=0 at a clock edge, the block SHALL clear the FSM to IDLE and set fetch_pc=RESET_PC and mem_addr=RESET_PC.
REQ-034 When reset=0 at a clock edge, the block SHALL drive mem_req=0, fifo_count=0, inst_valid=0, inst=16'h0000 and inst_pc=16'h0000.
REQ-035 Reset during REQ SHALL drop the request; an ack arriving after reset release with mem_req=0 SHALL be ignored.

Configuration
REQ-036 Macro FETCH_BYPASS_EN SHALL select the empty-FIFO bypass; when it is undefined, latency is per REQ-026 and inst is driven only from the FIFO.
REQ-037 With FETCH_BYPASS_EN defined, fifo_count=0 and mem_ack=1 in REQ with redirect=0 SHALL give inst_valid=1 in the same cycle, with inst=mem_rdata and inst_pc=fetch_pc.
REQ-038 With FETCH_BYPASS_EN defined and inst_ready=1 in the bypass cycle, the word SHALL be consumed and not pushed; otherwise it SHALL be pushed.

Verification
REQ-039 Reset-to-fill: reset low 2 cycles, then en=1, RAM acks 1 cycle after req, inst_ready=0 -> mem_addr 0000 then 0001, fifo_count reaches 2, mem_req=0 thereafter.
REQ-040 Streaming: RAM acks same cycle, inst_ready=1 -> decoder receives inst_pc 0000,0001,0002,... one per cycle after fill, fifo_count steady.
REQ-041 Redirect with a request outstanding: req at 0005 outstanding, redirect=1, redirect_pc=0040, ack 2 cycles later with 16'hDEAD -> DEAD never appears, next mem_addr=0040, fifo_count=0 after redirect.
REQ-042 Wrap: redirect_pc=FFFF, acks supplied -> inst_pc FFFF then 0000.
REQ-043 Simultaneous push and pop at fifo_count=1: push and pop in the same cycle -> count stays 1, order preserved; en=0 mid-REQ -> request completes, no new req.
REQ-044 FETCH_BYPASS_EN defined, empty FIFO, ack with 16'h1234, inst_ready=1 -> inst_valid=1 and inst=1234 in the ack cycle, fifo_count stays 0.
